// File: rtl/hazard_if.sv
// Hazard-controller bundle: ID/EX pipeline status in, stall/flush/multi-cycle controls out.
// slave is the controller side; master is the pipeline side.
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_IFID;
    logic [4:0]       rs2_IFID;
    logic             rs1_used_IFID;
    logic             rs2_used_IFID;
    logic [4:0]       rd_IDEX;
    logic             reg_wr_en_IDEX;
    logic             mem_rd_en_IDEX;
    logic             mc_op_IDEX;
    logic             mc_done;
    logic             branch_taken_EX;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             mc_start;
    logic             mc_busy;
    logic             mc_error;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  rs1_IFID, rs2_IFID, rs1_used_IFID, rs2_used_IFID, rd_IDEX,
               reg_wr_en_IDEX, mem_rd_en_IDEX, mc_op_IDEX, mc_done, branch_taken_EX,
        output pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
               mc_start, mc_busy, mc_error, stall_cycles
    );

    modport master (
        output rs1_IFID, rs2_IFID, rs1_used_IFID, rs2_used_IFID, rd_IDEX,
               reg_wr_en_IDEX, mem_rd_en_IDEX, mc_op_IDEX, mc_done, branch_taken_EX,
        input  pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
               mc_start, mc_busy, mc_error, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use/branch/multi-cycle hazard sequencer; stall/flush/start are same-cycle combinational.
// Multi-cycle ops hold the pipeline until mc_done or MC_TIMEOUT cycles; busy/error/counter are registered.
module hazard_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    localparam int WCNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mc_error_q, mc_error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic pc_stall_c, ifid_stall_c, idex_stall_c, ifid_flush_c, idex_flush_c, mc_start_c;
    logic load_use;
    logic release_c;

    assign load_use = hz.mem_rd_en_IDEX && hz.reg_wr_en_IDEX && (hz.rd_IDEX != 5'd0) &&
                      ((hz.rs1_used_IFID && (hz.rs1_IFID == hz.rd_IDEX)) ||
                       (hz.rs2_used_IFID && (hz.rs2_IFID == hz.rd_IDEX)));

    assign release_c = hz.mc_done || (wait_cnt_q == WCNT_W'(MC_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mc_error_d   = mc_error_q;
        pc_stall_c   = 1'b0;
        ifid_stall_c = 1'b0;
        idex_stall_c = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        mc_start_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.mc_op_IDEX) begin
                    mc_start_c   = 1'b1;
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_stall_c = 1'b1;
                    state_d      = WAIT;
                    wait_cnt_d   = '0;
                end else if (hz.branch_taken_EX) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    // The load keeps moving; a bubble goes in behind it.
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                if (release_c) begin
                    state_d = IDLE;
                    if (!hz.mc_done) mc_error_d = 1'b1;
                end else begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            pc_stall_c   = 1'b0;
            ifid_stall_c = 1'b0;
            idex_stall_c = 1'b0;
            ifid_flush_c = 1'b0;
            idex_flush_c = 1'b0;
            mc_start_c   = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mc_error_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mc_error_q  <= mc_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.ifid_stall   = ifid_stall_c;
    assign hz.idex_stall   = idex_stall_c;
    assign hz.ifid_flush   = ifid_flush_c;
    assign hz.idex_flush   = idex_flush_c;
    assign hz.mc_start     = mc_start_c;
    assign hz.mc_busy      = (state_q == WAIT);
    assign hz.mc_error     = mc_error_q;
    assign hz.stall_cycles = stall_cnt_q;
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the five-stage RISC-V core. It sits beside the EX-stage forwarding logic and handles the hazards forwarding cannot resolve:
- load-use stalls (bubble insertion);
- taken-branch flushes;
- multi-cycle EX operations (multiplier/MMM unit), via a start/done handshake FSM with a timeout.

It drives the stall and flush controls of the PC, IF/ID and ID/EX registers, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MC_TIMEOUT, 64: max WAIT cycles before forced release
- CNT_W, 32: stall counter width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- rs1_IFID, rs2_IFID  in  5  source registers of the instruction in ID
- rs1_used_IFID, rs2_used_IFID  in  1  ID instruction actually reads rs1/rs2
- rd_IDEX  in  5  destination of the instruction in EX
- reg_wr_en_IDEX  in  1  EX instruction writes rd
- mem_rd_en_IDEX  in  1  EX instruction is a load
- mc_op_IDEX  in  1  EX instruction is a multi-cycle op
- mc_done  in  1  one-cycle pulse from the multi-cycle unit; result valid
- branch_taken_EX  in  1  branch/jump in EX resolved taken
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_stall  out  1  hold ID/EX
- ifid_flush  out  1  zero IF/ID (NOP)
- idex_flush  out  1  zero ID/EX (bubble)
- mc_start  out  1  one-cycle start pulse to the multi-cycle unit
- mc_busy  out  1  FSM in WAIT
- mc_error  out  1  sticky; a timeout occurred
- stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating

## Operation
FSM states: IDLE, WAIT.

**IDLE**, evaluated in this priority:
1. mc_op_IDEX=1:
   - assert mc_start, pc_stall, ifid_stall, idex_stall;
   - next state WAIT; clear wait counter.
   - branch_taken_EX is ignored (the two inputs are illegal together; mc has priority).
2. branch_taken_EX=1:
   - assert ifid_flush and idex_flush; no stalls.
   - Overrides load-use, because the ID instruction is squashed.
3. Load-use: mem_rd_en_IDEX & reg_wr_en_IDEX & rd_IDEX≠0 & ((rs1_used_IFID & rs1_IFID==rd_IDEX) | (rs2_used_IFID & rs2_IFID==rd_IDEX)):
   - assert pc_stall, ifid_stall, idex_flush.
   - idex_stall stays 0, so the load advances.
4. Otherwise all control outputs are 0.

**WAIT:**
- mc_busy=1. pc_stall, ifid_stall and idex_stall are all 1 unless a release condition holds.
- Load-use and branch inputs are ignored.
- The wait counter increments each WAIT cycle.
- Release condition: mc_done=1, or wait counter == MC_TIMEOUT-1 (timeout).
- On release:
  - the three stalls are 0 that cycle, so the mc instruction advances with its result;
  - next state IDLE;
  - on timeout without mc_done, mc_error sets.
- mc_done in IDLE is ignored.

**Flush/stall semantics:** a flush has priority over a stall on the same register. The controller never asserts both on the same register.

**Stall counter:** stall_cycles increments each cycle pc_stall=1 and saturates at 2^CNT_W-1.

## Timing
- Reset:
  - FSM=IDLE, wait counter=0, mc_error=0, stall_cycles=0.
  - While reset=1, all stall/flush outputs and mc_start are forced to 0.
  - Reset mid-WAIT aborts to IDLE without setting mc_error; no further mc_start is issued.
- Combinational outputs (stalls, flushes, mc_start) respond in the same cycle as their inputs. mc_busy, mc_error and stall_cycles are registered.
- Multi-cycle op: start at cycle 0; mc_done at cycle L≥1.
  - Stalls are high for cycles 0..L-1, so L stall cycles in total.
  - mc_start is high only in cycle 0.
  - mc_busy is high in cycles 1..L.
- Timeout: with no mc_done, stalls are high for MC_TIMEOUT cycles (cycles 0..MC_TIMEOUT-1, released in cycle MC_TIMEOUT). mc_error reads 1 from cycle MC_TIMEOUT+1.
- Load-use costs exactly one bubble: the condition clears on the next cycle because the load has left EX.
- Back-to-back mc ops: a new mc_op_IDEX is seen in IDLE the cycle after release and restarts with no gap.

## Test plan
- **Load-use:** rd_IDEX=5, mem_rd_en=1, reg_wr_en=1, rs1_IFID=5, rs1_used=1 → pc_stall=ifid_stall=idex_flush=1 for one cycle, idex_stall=0, stall_cycles increments by 1. Repeat with rd_IDEX=0, or rs1_used=0 → no stall.
- **Branch beats load-use:** branch_taken_EX=1 with a load-use match → ifid_flush=idex_flush=1, pc_stall=0.
- **Multi-cycle op:** mc_op_IDEX=1, mc_done at L=4 → mc_start pulse at cycle 0 only; stalls high for cycles 0-3 and low at cycle 4; mc_busy high for cycles 1-4; stall_cycles=4; mc_error=0.
- **Timeout:** MC_TIMEOUT=8, mc_done never asserted → stalls high for 8 cycles, released in cycle 8; mc_error=1 from cycle 9 and stays 1 until reset.
- **Reset mid-WAIT:** reset at cycle 2 of WAIT → state IDLE, mc_busy=0, stall_cycles=0, mc_error=0; mc_done arriving after reset has no effect.
- **Saturation:** CNT_W=3, hold a load-use condition for 10 cycles → stall_cycles stops at 7.
